xmt_buf: RTL and testbench

XMT_BUF -- requirements
Module: xmt_buf

---
 rtl/xmt_buf.sv | 124 ++++++++++++
 tb/tb_xmt_buf.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/xmt_buf.sv
// 8N1 serial transmitter with a one-byte holding register in front of the shifter.
// A byte loaded while idle starts its frame on the following edge; further loads wait for empty.
module xmt_buf #(
  parameter int BIT_TIME = 1302
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] parallel_in,
  output logic       empty,
  output logic       serial_out
);

  localparam int CW = (BIT_TIME > 2) ? $clog2(BIT_TIME) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BIT_TIME - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    hold_dat_q, hold_dat_d;
  logic          empty_q, empty_d;
  logic          ser_q, ser_d;
  logic          bit_end;
  logic          xfer;

  assign empty      = empty_q;
  assign serial_out = ser_q;
  assign bit_end    = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      hold_dat_q <= '0;
      empty_q    <= 1'b1;
      ser_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      hold_dat_q <= hold_dat_d;
      empty_q    <= empty_d;
      ser_q      <= ser_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    hold_dat_d = hold_dat_q;
    empty_d    = empty_q;
    ser_d      = ser_q;
    xfer       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty_q) xfer = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
          ser_d   = shreg_q[0];
          cnt_d   = RELOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = RELOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            ser_d   = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shreg_d = shreg_q >> 1;
            ser_d   = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty_q) begin
            xfer = 1'b1;
          end else begin
            state_d = IDLE;
            ser_d   = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Transfer needs a full holding register and load acceptance needs an empty one,
    // so the two can never collide on the same edge.
    if (xfer) begin
      state_d = START;
      ser_d   = 1'b0;
      shreg_d = hold_dat_q;
      empty_d = 1'b1;
      cnt_d   = RELOAD;
    end

    if (load && empty_q) begin
      hold_dat_d = parallel_in;
      empty_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_xmt_buf.sv
// Directed bench for xmt_buf: a short-bit-time instance for framing and buffering,
// and a BIT_TIME=2 instance for the minimum-width corner.
module tb_xmt_buf;

  localparam int BT  = 5;
  localparam int BT2 = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] parallel_in = 8'h00;
  logic       empty;
  logic       serial_out;
  logic       load2 = 1'b0;
  logic [7:0] parallel_in2 = 8'h00;
  logic       empty2;
  logic       serial_out2;

  int checks = 0;
  int errors = 0;

  xmt_buf #(.BIT_TIME(BT)) u_dut (
    .clk(clk), .reset(reset), .load(load), .parallel_in(parallel_in),
    .empty(empty), .serial_out(serial_out)
  );

  xmt_buf #(.BIT_TIME(BT2)) u_dut2 (
    .clk(clk), .reset(reset), .load(load2), .parallel_in(parallel_in2),
    .empty(empty2), .serial_out(serial_out2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  // Called right after the edge that starts the start bit; returns right after the
  // edge that ends the stop bit. Optional loads are pulsed for one edge at given sample indices.
  task automatic frame(input string tag, input logic [7:0] b,
                       input int ia, input logic [7:0] va,
                       input int ib, input logic [7:0] vb);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BT; c++) begin
        int n;
        n = i * BT + c;
        chk($sformatf("%s bit%0d cyc%0d", tag, i, c), {7'd0, serial_out}, {7'd0, frame_bit(b, i)});
        if (n == ia) begin load = 1'b1; parallel_in = va; end
        if (n == ib) begin load = 1'b1; parallel_in = vb; end
        tick();
        load = 1'b0;
        parallel_in = 8'hC3;
      end
    end
  endtask

  task automatic start_byte(input string tag, input logic [7:0] b);
    load = 1'b1;
    parallel_in = b;
    tick();
    load = 1'b0;
    parallel_in = ~b;
    chk({tag, " empty after load"}, {7'd0, empty}, 8'd0);
    chk({tag, " line idle after load"}, {7'd0, serial_out}, 8'd1);
    tick();
    chk({tag, " empty after transfer"}, {7'd0, empty}, 8'd1);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s idle line %0d", tag, k), {7'd0, serial_out}, 8'd1);
      chk($sformatf("%s idle empty %0d", tag, k), {7'd0, empty}, 8'd1);
      tick();
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset serial_out", {7'd0, serial_out}, 8'd1);
    chk("reset empty", {7'd0, empty}, 8'd1);
    chk("reset serial_out2", {7'd0, serial_out2}, 8'd1);
    chk("reset empty2", {7'd0, empty2}, 8'd1);

    // Single byte; load on the first edge out of reset is accepted
    reset = 1'b0;
    start_byte("b55", 8'h55);
    frame("b55", 8'h55, -1, 8'h00, -1, 8'h00);
    idle_check("b55", 8);

    // Back-to-back frames; 0x77 lands on the transfer edge and must be dropped
    start_byte("bA5", 8'hA5);
    frame("bA5", 8'hA5, 0, 8'h3C, 10 * BT - 1, 8'h77);
    frame("b3C", 8'h3C, -1, 8'h00, -1, 8'h00);
    idle_check("b3C", 8);

    // Second byte buffered, third load while full is ignored
    start_byte("b11", 8'h11);
    frame("b11", 8'h11, 0, 8'h22, 23, 8'h33);
    frame("b22", 8'h22, -1, 8'h00, -1, 8'h00);
    idle_check("b22", 8);

    // Reset mid-frame aborts the frame and drops the buffered byte
    start_byte("bFF", 8'hFF);
    load = 1'b1;
    parallel_in = 8'hEE;
    tick();
    load = 1'b0;
    tick();
    chk("abort start bit low", {7'd0, serial_out}, 8'd0);
    chk("abort holding full", {7'd0, empty}, 8'd0);
    reset = 1'b1;
    tick();
    chk("abort serial_out", {7'd0, serial_out}, 8'd1);
    chk("abort empty", {7'd0, empty}, 8'd1);
    reset = 1'b0;
    idle_check("post abort", 30);
    start_byte("b0F", 8'h0F);
    frame("b0F", 8'h0F, -1, 8'h00, -1, 8'h00);
    idle_check("b0F", 4);

    // Continuous stream of edge-case bytes
    start_byte("b00", 8'h00);
    frame("b00", 8'h00, 0, 8'hFF, -1, 8'h00);
    frame("bFF2", 8'hFF, 0, 8'h80, -1, 8'h00);
    frame("b80", 8'h80, 0, 8'h01, -1, 8'h00);
    frame("b01", 8'h01, -1, 8'h00, -1, 8'h00);
    idle_check("b01", 4);

    // Minimum bit time instance
    load2 = 1'b1;
    parallel_in2 = 8'h96;
    tick();
    load2 = 1'b0;
    parallel_in2 = 8'h00;
    chk("bt2 empty after load", {7'd0, empty2}, 8'd0);
    tick();
    chk("bt2 empty after transfer", {7'd0, empty2}, 8'd1);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BT2; c++) begin
        chk($sformatf("bt2 b96 bit%0d cyc%0d", i, c), {7'd0, serial_out2}, {7'd0, frame_bit(8'h96, i)});
        tick();
      end
    end
    chk("bt2 idle line", {7'd0, serial_out2}, 8'd1);
    chk("bt2 idle empty", {7'd0, empty2}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
